// File: rtl/qtcore_pkg.sv
// Shared qtcore constants: PC mux select encodings and default datapath widths.
package qtcore_pkg;

    localparam int unsigned PC_WIDTH_DEFAULT    = 5;
    localparam int unsigned INSTR_WIDTH_DEFAULT = 8;

    localparam logic [1:0] PC_SEL_INC = 2'b00;
    localparam logic [1:0] PC_SEL_ACC = 2'b01;
    localparam logic [1:0] PC_SEL_BWD = 2'b10;
    localparam logic [1:0] PC_SEL_FWD = 2'b11;

endpackage

// File: rtl/scan_load_reg.sv
// Register with synchronous active-low reset, serial shift (MSB out) and parallel load.
// Priority per edge: reset > shift > load > hold.
module scan_load_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             shift_in,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] q,
    output logic             shift_out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (shift_en) begin
            data_d = {data_q[WIDTH-2:0], shift_in};
        end else if (load_en) begin
            data_d = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign q         = data_q;
    assign shift_out = data_q[WIDTH-1];

endmodule

// File: rtl/pc_ir_fetch_unit.sv
// Program counter and instruction register for the qtcore datapath; PC then IR form one scan segment.
// Optional breakpoint comparator enabled by defining PC_IR_BREAKPOINT_EN.
module pc_ir_fetch_unit
    import qtcore_pkg::*;
#(
    parameter int unsigned PC_WIDTH    = PC_WIDTH_DEFAULT,
    parameter int unsigned INSTR_WIDTH = INSTR_WIDTH_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   processor_enable,
    input  logic                   PC_write_enable,
    input  logic [1:0]             PC_mux_select,
    input  logic                   IR_load_enable,
    input  logic [INSTR_WIDTH-1:0] acc_in,
    input  logic [INSTR_WIDTH-1:0] mem_data_in,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [INSTR_WIDTH-1:0] instruction,
`ifdef PC_IR_BREAKPOINT_EN
    input  logic [PC_WIDTH-1:0]    bp_addr,
    input  logic                   bp_valid,
    input  logic                   bp_clear,
    output logic                   bp_hit,
`endif
    input  logic                   scan_enable,
    input  logic                   scan_in,
    output logic                   scan_out
);

    logic [PC_WIDTH-1:0]    pc_cur;
    logic [INSTR_WIDTH-1:0] ir_cur;
    logic [PC_WIDTH-1:0]    next_pc;
    logic                   pc_chain;
    logic                   pc_load;
    logic                   ir_load;

    // Only the low PC_WIDTH bits of the accumulator form a jump target.
    logic unused_acc_bits;
    assign unused_acc_bits = ^acc_in[INSTR_WIDTH-1:PC_WIDTH];

    assign pc_load = processor_enable & PC_write_enable;
    assign ir_load = processor_enable & IR_load_enable;

    always_comb begin
        next_pc = pc_cur + PC_WIDTH'(1);
        unique case (PC_mux_select)
            PC_SEL_INC: next_pc = pc_cur + PC_WIDTH'(1);
            PC_SEL_ACC: next_pc = acc_in[PC_WIDTH-1:0];
            PC_SEL_BWD: next_pc = pc_cur - PC_WIDTH'(3);
            PC_SEL_FWD: next_pc = pc_cur + PC_WIDTH'(2);
            default:    ;
        endcase
    end

    scan_load_reg #(
        .WIDTH (PC_WIDTH)
    ) u_pc_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (scan_enable),
        .shift_in  (scan_in),
        .load_en   (pc_load),
        .load_data (next_pc),
        .q         (pc_cur),
        .shift_out (pc_chain)
    );

    scan_load_reg #(
        .WIDTH (INSTR_WIDTH)
    ) u_ir_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_en  (scan_enable),
        .shift_in  (pc_chain),
        .load_en   (ir_load),
        .load_data (mem_data_in),
        .q         (ir_cur),
        .shift_out (scan_out)
    );

    assign pc_out      = pc_cur;
    assign instruction = ir_cur;

`ifdef PC_IR_BREAKPOINT_EN
    logic bp_hit_q;
    logic bp_hit_d;
    logic bp_set;

    // Only a real functional PC load can trigger; scan shifting never does.
    assign bp_set = ~scan_enable & pc_load & bp_valid & (next_pc == bp_addr);

    always_comb begin
        bp_hit_d = bp_hit_q;
        if (bp_set) begin
            bp_hit_d = 1'b1;
        end else if (bp_clear) begin
            bp_hit_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bp_hit_q <= 1'b0;
        end else begin
            bp_hit_q <= bp_hit_d;
        end
    end

    assign bp_hit = bp_hit_q;
`endif

endmodule

// File: tb/tb_pc_ir_fetch_unit.sv
// Directed self-checking bench for pc_ir_fetch_unit (breakpoint checks when PC_IR_BREAKPOINT_EN is set).
module tb_pc_ir_fetch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       processor_enable;
    logic       PC_write_enable;
    logic [1:0] PC_mux_select;
    logic       IR_load_enable;
    logic [7:0] acc_in;
    logic [7:0] mem_data_in;
    logic [4:0] pc_out;
    logic [7:0] instruction;
    logic       scan_enable;
    logic       scan_in;
    logic       scan_out;
`ifdef PC_IR_BREAKPOINT_EN
    logic [4:0] bp_addr;
    logic       bp_valid;
    logic       bp_clear;
    logic       bp_hit;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    pc_ir_fetch_unit #(
        .PC_WIDTH    (5),
        .INSTR_WIDTH (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .processor_enable (processor_enable),
        .PC_write_enable  (PC_write_enable),
        .PC_mux_select    (PC_mux_select),
        .IR_load_enable   (IR_load_enable),
        .acc_in           (acc_in),
        .mem_data_in      (mem_data_in),
        .pc_out           (pc_out),
        .instruction      (instruction),
`ifdef PC_IR_BREAKPOINT_EN
        .bp_addr          (bp_addr),
        .bp_valid         (bp_valid),
        .bp_clear         (bp_clear),
        .bp_hit           (bp_hit),
`endif
        .scan_enable      (scan_enable),
        .scan_in          (scan_in),
        .scan_out         (scan_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        processor_enable = 1'b0;
        PC_write_enable  = 1'b0;
        IR_load_enable   = 1'b0;
        PC_mux_select    = 2'b00;
        scan_enable      = 1'b0;
        scan_in          = 1'b0;
    endtask

    // First bit shifted lands in IR MSB, so shift IR[7..0] then PC[4..0].
    task automatic scan_load(input logic [4:0] pc, input logic [7:0] ir);
        logic [12:0] bits;
        bits = {ir, pc};
        scan_enable = 1'b1;
        for (int i = 12; i >= 0; i--) begin
            scan_in = bits[i];
            step();
        end
        scan_enable = 1'b0;
        scan_in     = 1'b0;
    endtask

    task automatic test_reset();
        scan_load(5'h0A, 8'h3C);
        vectors++;
        if (pc_out !== 5'h0A) begin
            $display("FAIL preload_pc: got %h want 0a", pc_out); errors++;
        end
        vectors++;
        if (instruction !== 8'h3C) begin
            $display("FAIL preload_ir: got %h want 3c", instruction); errors++;
        end
        rst_n = 1'b0; scan_enable = 1'b1; scan_in = 1'b1;
        processor_enable = 1'b1; PC_write_enable = 1'b1; IR_load_enable = 1'b1;
        mem_data_in = 8'hFF;
        step();
        rst_n = 1'b1;
        idle();
        vectors++;
        if (pc_out !== 5'h00) begin
            $display("FAIL reset_pc: got %h want 00", pc_out); errors++;
        end
        vectors++;
        if (instruction !== 8'h00) begin
            $display("FAIL reset_ir: got %h want 00", instruction); errors++;
        end
        vectors++;
        if (scan_out !== 1'b0) begin
            $display("FAIL reset_scan_out: got %b want 0", scan_out); errors++;
        end
`ifdef PC_IR_BREAKPOINT_EN
        vectors++;
        if (bp_hit !== 1'b0) begin
            $display("FAIL reset_bp_hit: got %b want 0", bp_hit); errors++;
        end
`endif
    endtask

    task automatic test_fetch();
        scan_load(5'h04, 8'h00);
        mem_data_in = 8'h25;
        processor_enable = 1'b1; PC_write_enable = 1'b1; IR_load_enable = 1'b1;
        PC_mux_select = 2'b00;
        step();
        idle();
        vectors++;
        if (pc_out !== 5'h05) begin
            $display("FAIL fetch_pc: got %h want 05", pc_out); errors++;
        end
        vectors++;
        if (instruction !== 8'h25) begin
            $display("FAIL fetch_ir: got %h want 25", instruction); errors++;
        end
        // Functional enable with no write enables: everything holds.
        processor_enable = 1'b1; mem_data_in = 8'h99;
        step();
        idle();
        vectors++;
        if (pc_out !== 5'h05 || instruction !== 8'h25) begin
            $display("FAIL fetch_hold: got pc %h ir %h want 05 25", pc_out, instruction); errors++;
        end
    endtask

    task automatic test_wrap();
        logic [4:0] start_pc [4];
        logic [1:0] sel      [4];
        logic [4:0] exp_pc   [4];
        start_pc = '{5'h1F, 5'h01, 5'h1E, 5'h03};
        sel      = '{2'b00, 2'b10, 2'b11, 2'b01};
        exp_pc   = '{5'h00, 5'h1E, 5'h00, 5'h1F};
        acc_in = 8'h9F;
        for (int i = 0; i < 4; i++) begin
            scan_load(start_pc[i], 8'h5A);
            processor_enable = 1'b1; PC_write_enable = 1'b1; PC_mux_select = sel[i];
            step();
            idle();
            vectors++;
            if (pc_out !== exp_pc[i]) begin
                $display("FAIL wrap_%0d: got %h want %h", i, pc_out, exp_pc[i]); errors++;
            end
            vectors++;
            if (instruction !== 8'h5A) begin
                $display("FAIL wrap_ir_hold_%0d: got %h want 5a", i, instruction); errors++;
            end
        end
    endtask

    task automatic test_hold();
        scan_load(5'h09, 8'hC3);
        processor_enable = 1'b0; PC_write_enable = 1'b1; IR_load_enable = 1'b1;
        mem_data_in = 8'h11; acc_in = 8'h02; PC_mux_select = 2'b01;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (pc_out !== 5'h09 || instruction !== 8'hC3) begin
                $display("FAIL hold_%0d: got pc %h ir %h want 09 c3", i, pc_out, instruction);
                errors++;
            end
        end
        idle();
    endtask

    task automatic test_scan();
        logic [12:0] pat;
        pat = 13'b1_0110_1001_0011;
        scan_enable = 1'b1;
        // Functional enables must be ignored while shifting.
        processor_enable = 1'b1; PC_write_enable = 1'b1; IR_load_enable = 1'b1;
        for (int i = 12; i >= 0; i--) begin
            scan_in = pat[i];
            step();
        end
        vectors++;
        if (instruction !== 8'hB4) begin
            $display("FAIL scan_ir: got %h want b4", instruction); errors++;
        end
        vectors++;
        if (pc_out !== 5'h13) begin
            $display("FAIL scan_pc: got %h want 13", pc_out); errors++;
        end
        for (int i = 12; i >= 0; i--) begin
            vectors++;
            if (scan_out !== pat[i]) begin
                $display("FAIL scan_out_bit_%0d: got %b want %b", 12 - i, scan_out, pat[i]);
                errors++;
            end
            scan_in = 1'b0;
            step();
        end
        idle();
        // Reset mid-scan discards the partial shift.
        scan_enable = 1'b1; scan_in = 1'b1;
        step(); step(); step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        idle();
        vectors++;
        if (pc_out !== 5'h00 || instruction !== 8'h00) begin
            $display("FAIL scan_reset: got pc %h ir %h want 00 00", pc_out, instruction); errors++;
        end
    endtask

`ifdef PC_IR_BREAKPOINT_EN
    task automatic test_breakpoint();
        bp_addr = 5'h07; bp_valid = 1'b1; bp_clear = 1'b0;
        scan_load(5'h06, 8'h00);
        processor_enable = 1'b1; PC_write_enable = 1'b1; PC_mux_select = 2'b00;
        step();
        idle();
        vectors++;
        if (pc_out !== 5'h07 || bp_hit !== 1'b1) begin
            $display("FAIL bp_set: got pc %h hit %b want 07 1", pc_out, bp_hit); errors++;
        end
        step(); step();
        vectors++;
        if (bp_hit !== 1'b1) begin
            $display("FAIL bp_sticky: got %b want 1", bp_hit); errors++;
        end
        bp_clear = 1'b1;
        step();
        bp_clear = 1'b0;
        vectors++;
        if (bp_hit !== 1'b0) begin
            $display("FAIL bp_clear: got %b want 0", bp_hit); errors++;
        end
        bp_valid = 1'b0;
        scan_load(5'h06, 8'h00);
        processor_enable = 1'b1; PC_write_enable = 1'b1;
        step();
        idle();
        vectors++;
        if (pc_out !== 5'h07 || bp_hit !== 1'b0) begin
            $display("FAIL bp_invalid: got pc %h hit %b want 07 0", pc_out, bp_hit); errors++;
        end
        bp_valid = 1'b1; bp_clear = 1'b1;
        scan_load(5'h06, 8'h00);
        processor_enable = 1'b1; PC_write_enable = 1'b1;
        step();
        idle();
        bp_clear = 1'b0;
        vectors++;
        if (bp_hit !== 1'b1) begin
            $display("FAIL bp_set_wins: got %b want 1", bp_hit); errors++;
        end
    endtask
`endif

    initial begin
        idle();
        rst_n = 1'b0;
        acc_in = 8'h00;
        mem_data_in = 8'h00;
`ifdef PC_IR_BREAKPOINT_EN
        bp_addr = 5'h00; bp_valid = 1'b0; bp_clear = 1'b0;
`endif
        step();
        rst_n = 1'b1;
        test_reset();
        test_fetch();
        test_wrap();
        test_hold();
        test_scan();
`ifdef PC_IR_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
